// File: rtl/dw_seq_op_ctrl.sv
// Initiator for a sequential start/complete FP operator with a timeout watchdog.
// Latency: op_start one cycle after accept; out_valid one cycle after first qualified complete.
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE or HOLD with out_ready.
`timescale 1ns/1ps
`default_nettype none

module dw_seq_op_ctrl #(
    parameter int SIG_WIDTH   = 23,
    parameter int EXP_WIDTH   = 8,
    parameter int TIMEOUT_CYC = 16,
    localparam int W = SIG_WIDTH + EXP_WIDTH + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [2:0]   in_rnd,
    output logic [W-1:0] op_a,
    output logic [W-1:0] op_b,
    output logic [2:0]   op_rnd,
    output logic         op_start,
    input  logic [W-1:0] op_z,
    input  logic [7:0]   op_status,
    input  logic         op_complete,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_z,
    output logic [7:0]   out_status,
    output logic         out_err,
    output logic         busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

    logic [1:0] state;
    logic [7:0] cnt;
    logic       accept;
    logic       cmpl_hit;
    logic       tmo_hit;

    // HOLD with out_ready frees the slot in the same cycle, so a queued pair goes straight to START.
    assign in_ready = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);

    // cnt==0 masks a complete still high from the previous operation.
    assign cmpl_hit = (state == ST_WAIT) && (cnt != 8'd0) && op_complete;
    assign tmo_hit  = (state == ST_WAIT) && (cnt == TMO) && !op_complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            op_a       <= '0;
            op_b       <= '0;
            op_rnd     <= 3'd0;
            op_start   <= 1'b0;
            out_valid  <= 1'b0;
            out_z      <= '0;
            out_status <= 8'h00;
            out_err    <= 1'b0;
        end else begin
            op_start <= 1'b0;
            if (accept) begin
                op_a      <= in_a;
                op_b      <= in_b;
                op_rnd    <= in_rnd;
                op_start  <= 1'b1;
                cnt       <= 8'd0;
                out_valid <= 1'b0;
                state     <= ST_START;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_START: begin
                        cnt   <= 8'd0;
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (cnt != TMO) begin
                            cnt <= cnt + 8'd1;
                        end
                        if (cmpl_hit) begin
                            out_z      <= op_z;
                            out_status <= op_status;
                            out_err    <= 1'b0;
                            out_valid  <= 1'b1;
                            state      <= ST_HOLD;
                        end else if (tmo_hit) begin
                            out_z      <= '0;
                            out_status <= 8'h00;
                            out_err    <= 1'b1;
                            out_valid  <= 1'b1;
                            state      <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dw_seq_op_ctrl.sv
// Bench for dw_seq_op_ctrl: stub operator with per-op latency, vector table, directed corners, random traffic.
`timescale 1ns/1ps

module tb_dw_seq_op_ctrl;

    localparam int W  = 32;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] in_a, in_b;
    logic [2:0]   in_rnd;
    logic [W-1:0] op_a, op_b;
    logic [2:0]   op_rnd;
    logic         op_start;
    logic [W-1:0] op_z = '0;
    logic [7:0]   op_status = 8'h00;
    logic         op_complete = 1'b0;
    logic         out_valid, out_ready;
    logic [W-1:0] out_z;
    logic [7:0]   out_status;
    logic         out_err, busy;

    always #5 clk = ~clk;

    dw_seq_op_ctrl #(.SIG_WIDTH(23), .EXP_WIDTH(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_rnd(in_rnd),
        .op_a(op_a), .op_b(op_b), .op_rnd(op_rnd), .op_start(op_start),
        .op_z(op_z), .op_status(op_status), .op_complete(op_complete),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
        .out_status(out_status), .out_err(out_err), .busy(busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   rnd;
        int           lat;    // stub latency after op_start; 0 = never completes
        logic [W-1:0] z;
        logic [7:0]   st;
        logic         err;
        int           delta;  // cycles from op_start to first out_valid
    } op_t;

    op_t src_q[$];
    op_t exp_q[$];
    int  lat_q[$];
    int  start_q[$];
    int  all_starts[$];
    op_t tbl[9];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit stub_stale = 1'b0;
    bit ov_seen = 1'b0;
    logic [W-1:0] snap_z;
    logic [7:0]   snap_st;
    logic         snap_err;

    // Stand-in operator: a few real quotients, otherwise an arbitrary mix of the operands.
    function automatic logic [W-1:0] fz(input logic [W-1:0] a, input logic [W-1:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h3F000000;
            64'h40C00000_40400000: return 32'h40000000;
            64'h41100000_40400000: return 32'h40400000;
            64'h3F800000_40800000: return 32'h3E800000;
            default:               return a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    function automatic logic [7:0] fs(input logic [W-1:0] a, input logic [W-1:0] b);
        return a[7:0] | b[7:0];
    endfunction

    // Reference: complete is seen at WAIT count lat-1 (never before 1); beyond TO the watchdog fires.
    function automatic op_t make_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [2:0] rnd, input int lat);
        op_t o;
        o.a = a; o.b = b; o.rnd = rnd; o.lat = lat;
        o.err   = (lat == 0) || (lat - 1 > TO);
        o.z     = o.err ? '0 : fz(a, b);
        o.st    = o.err ? 8'h00 : fs(a, b);
        o.delta = o.err ? TO + 2 : ((lat < 2) ? 2 : lat) + 1;
        return o;
    endfunction

    int stub_l;
    int stub_cnt = 0;
    logic [W-1:0] pend_z;
    logic [7:0]   pend_st;

    always @(posedge clk) begin
        if (op_start) begin
            stub_l  = (lat_q.size() > 0) ? lat_q.pop_front() : 4;
            pend_z  <= fz(op_a, op_b);
            pend_st <= fs(op_a, op_b);
            if (stub_stale) begin
                op_complete <= 1'b1;   // never drops; result updates one edge later
                stub_cnt    <= 1;
            end else if (stub_l == 1) begin
                op_complete <= 1'b1;
                op_z        <= fz(op_a, op_b);
                op_status   <= fs(op_a, op_b);
                stub_cnt    <= 0;
            end else begin
                op_complete <= 1'b0;
                stub_cnt    <= (stub_l == 0) ? 0 : stub_l - 1;
            end
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                op_complete <= 1'b1;
                op_z        <= pend_z;
                op_status   <= pend_st;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic monitor();
        int i;
        if (op_start) begin
            i = start_q.size();
            check("start_has_op", 64'(i < exp_q.size()), 64'd1);
            if (i < exp_q.size()) begin
                check("op_a", 64'(op_a), 64'(exp_q[i].a));
                check("op_b", 64'(op_b), 64'(exp_q[i].b));
                check("op_rnd", 64'(op_rnd), 64'(exp_q[i].rnd));
            end
            start_q.push_back(cyc);
            all_starts.push_back(cyc);
        end
        if (exp_q.size() == 0) check("idle_out_valid", 64'(out_valid), 64'd0);
        if (out_valid && exp_q.size() > 0) begin
            check("out_after_start", 64'(start_q.size() > 0), 64'd1);
            if (!ov_seen && start_q.size() > 0) begin
                ov_seen = 1'b1;
                check("out_z", 64'(out_z), 64'(exp_q[0].z));
                check("out_status", 64'(out_status), 64'(exp_q[0].st));
                check("out_err", 64'(out_err), 64'(exp_q[0].err));
                check("latency", 64'(cyc - start_q[0]), 64'(exp_q[0].delta));
                snap_z = out_z; snap_st = out_status; snap_err = out_err;
            end else if (ov_seen) begin
                check("hold_z", 64'(out_z), 64'(snap_z));
                check("hold_status", 64'(out_status), 64'(snap_st));
                check("hold_err", 64'(out_err), 64'(snap_err));
            end
            if (out_ready) begin
                void'(exp_q.pop_front());
                if (start_q.size() > 0) void'(start_q.pop_front());
                ov_seen = 1'b0;
            end
        end
    endtask

    // Streams src_q through the DUT; hold_cyc>0 stalls each result that many cycles before taking it.
    task automatic run(input int ready_pct, input int gap_pct, input int hold_cyc, input int budget);
        int  t = 0;
        int  held = 0;
        bit  fire;
        bit  ofire;
        in_valid = 1'b0;
        while ((src_q.size() > 0 || exp_q.size() > 0) && t < budget) begin
            if (!in_valid && src_q.size() > 0 && $urandom_range(99) >= gap_pct) in_valid = 1'b1;
            if (in_valid) begin
                in_a = src_q[0].a; in_b = src_q[0].b; in_rnd = src_q[0].rnd;
            end else begin
                in_a = $urandom; in_b = $urandom; in_rnd = 3'($urandom);
            end
            out_ready = (hold_cyc > 0) ? (ov_seen && held >= hold_cyc)
                                       : ($urandom_range(99) < ready_pct);
            #1;
            fire  = in_valid && in_ready;
            ofire = out_valid && out_ready;
            monitor();
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_no_start", 64'(op_start), 64'd0);
                held++;
            end
            if (ofire) held = 0;
            if (fire) begin
                exp_q.push_back(src_q[0]);
                lat_q.push_back(src_q[0].lat);
                void'(src_q.pop_front());
            end
            tick();
            t++;
            if (fire) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        if (t >= budget) begin
            check("run_budget", 64'(t), 64'(budget - 1));
            src_q.delete(); exp_q.delete(); start_q.delete(); ov_seen = 1'b0;
        end
    endtask

    initial begin
        int base;
        //        a              b              rnd   lat z              st     err  delta
        tbl[0] = '{32'h3F800000, 32'h40000000, 3'd0, 4,  32'h3F000000, 8'h00, 1'b0, 5};
        tbl[1] = '{32'h40C00000, 32'h40400000, 3'd0, 4,  32'h40000000, 8'h00, 1'b0, 5};
        tbl[2] = '{32'h41100000, 32'h40400000, 3'd1, 4,  32'h40400000, 8'h00, 1'b0, 5};
        tbl[3] = '{32'h3F800000, 32'h40800000, 3'd2, 4,  32'h3E800000, 8'h00, 1'b0, 5};
        tbl[4] = '{32'h3F800000, 32'h40800000, 3'd3, 1,  32'h3E800000, 8'h00, 1'b0, 3};
        tbl[5] = '{32'h12345678, 32'h0F0F0000, 3'd4, 3,  32'h12345977, 8'h78, 1'b0, 4};
        tbl[6] = '{32'h3F800000, 32'h40000000, 3'd5, 17, 32'h3F000000, 8'h00, 1'b0, 18};
        tbl[7] = '{32'h3F800000, 32'h40000000, 3'd6, 18, 32'h00000000, 8'h00, 1'b1, 18};
        tbl[8] = '{32'hDEADBEEF, 32'h01234567, 3'd7, 0,  32'h00000000, 8'h00, 1'b1, 18};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_rnd = 3'd0; out_ready = 1'b0;
        repeat (3) tick();
        #1;
        check("rst_op_a", 64'(op_a), 64'd0);
        check("rst_op_b", 64'(op_b), 64'd0);
        check("rst_op_rnd", 64'(op_rnd), 64'd0);
        check("rst_op_start", 64'(op_start), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_z", 64'(out_z), 64'd0);
        check("rst_out_status", 64'(out_status), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        rst = 1'b0;
        tick();

        // Single op: exactly one start pulse
        base = all_starts.size();
        src_q.push_back(tbl[0]);
        run(100, 0, 0, 200);
        check("single_starts", 64'(all_starts.size() - base), 64'd1);

        // Back-to-back: HOLD hands straight to START, so starts are delta+1 apart
        base = all_starts.size();
        for (int i = 1; i <= 3; i++) src_q.push_back(tbl[i]);
        run(100, 0, 0, 200);
        check("b2b_starts", 64'(all_starts.size() - base), 64'd3);
        if (all_starts.size() - base == 3) begin
            check("b2b_gap1", 64'(all_starts[base + 1] - all_starts[base]), 64'd6);
            check("b2b_gap2", 64'(all_starts[base + 2] - all_starts[base + 1]), 64'd6);
        end

        // Remaining table rows: minimum latency, non-zero status, complete/timeout boundary, hang
        for (int i = 4; i < 9; i++) src_q.push_back(tbl[i]);
        run(100, 0, 0, 400);

        // Backpressure: each result stalled 10 cycles while the next pair waits
        src_q.push_back(make_op(32'h3F800000, 32'h40000000, 3'd0, 3));
        src_q.push_back(make_op(32'hCAFEF00D, 32'h00C0FFEE, 3'd1, 5));
        run(100, 0, 10, 200);

        // Stale complete held high across operations
        stub_stale = 1'b1;
        src_q.push_back(make_op(32'h40C00000, 32'h40400000, 3'd0, 2));
        src_q.push_back(make_op(32'h41100000, 32'h40400000, 3'd0, 2));
        src_q.push_back(make_op(32'hA5A5A5A5, 32'h5A5A0101, 3'd2, 2));
        run(100, 0, 0, 200);
        stub_stale = 1'b0;

        // Reset at WAIT cnt=2 discards the operation; the late complete is ignored
        in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40800000; in_rnd = 3'd3; out_ready = 1'b1;
        lat_q.push_back(6);
        #1;
        check("rw_accept_rdy", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check("rw_start", 64'(op_start), 64'd1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        #1;
        check("rw_busy", 64'(busy), 64'd0);
        check("rw_out_valid", 64'(out_valid), 64'd0);
        check("rw_op_a", 64'(op_a), 64'd0);
        check("rw_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            check("rw_after_out_valid", 64'(out_valid), 64'd0);
            check("rw_after_busy", 64'(busy), 64'd0);
        end
        check("rw_stub_completed", 64'(op_complete), 64'd1);
        out_ready = 1'b0;
        tick();

        // Random traffic against the reference
        for (int i = 0; i < 60; i++)
            src_q.push_back(make_op($urandom, $urandom, 3'($urandom), $urandom_range(0, 20)));
        run(70, 30, 0, 20000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dw_seq_op_ctrl.md
Name: dw_seq_op_ctrl

Overview:
- Initiator-side controller for a sequential DesignWare-style floating-point operator (start/complete handshake, e.g. a sequential FP divider).
- Accepts operand pairs from an upstream valid/ready stream and drives the operator's operands and start pulse.
- Waits for complete, captures z/status, and presents the result on a downstream valid/ready stream.
- Adds a timeout watchdog so a hung operator cannot stall the pipeline.

Parameters:
- SIG_WIDTH, 23, significand field width of operands/result.
- EXP_WIDTH, 8, exponent field width; W = SIG_WIDTH+EXP_WIDTH+1.
- TIMEOUT_CYC, 16, WAIT cycles before abort; legal range 3..255; must exceed the operator's num_cyc+1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream operand pair valid.
- in_ready  out  1  controller can accept an operand pair.
- in_a  in  W  dividend/operand A.
- in_b  in  W  divisor/operand B.
- in_rnd  in  3  rounding mode.
- op_a  out  W  operand A to operator.
- op_b  out  W  operand B to operator.
- op_rnd  out  3  rounding mode to operator.
- op_start  out  1  one-cycle start pulse to operator.
- op_z  in  W  operator result.
- op_status  in  8  operator status flags.
- op_complete  in  1  operator result valid (level).
- out_valid  out  1  result valid downstream.
- out_ready  in  1  downstream accepts result.
- out_z  out  W  captured result.
- out_status  out  8  captured status.
- out_err  out  1  result produced by timeout abort.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous): state=IDLE, cnt=0. op_a/op_b/op_rnd/out_z/out_status=0. op_start=0, out_valid=0, out_err=0, busy=0.
- States are IDLE, START, WAIT and HOLD.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). This is combinational and lets back-to-back operations run with no bubble.
- Accept: in_valid && in_ready on an edge latches in_a/in_b/in_rnd into op_a/op_b/op_rnd; next state=START.
- op_a/op_b/op_rnd hold stable from accept until the next accept. The operator may run in either input mode.
- START: op_start=1 for exactly this cycle. cnt<=0. Next state=WAIT.
- WAIT: op_start=0 and cnt increments each cycle, saturating at TIMEOUT_CYC.
- op_complete is ignored while cnt==0, i.e. the first WAIT cycle. This masks a complete left high from the previous operation.
- Completion: in WAIT with cnt>=1 and op_complete=1, capture out_z<=op_z and out_status<=op_status, set out_err<=0 and out_valid<=1; next state=HOLD.
- Timeout: in WAIT with cnt==TIMEOUT_CYC and op_complete=0, set out_z<=0, out_status<=8'h00, out_err<=1, out_valid<=1; next state=HOLD.
- If complete and timeout coincide, complete wins and out_err=0.
- HOLD: out_valid=1 and out_z/out_status/out_err stay stable until out_ready.
  - out_ready && !in_valid: next state=IDLE, out_valid<=0.
  - out_ready && in_valid: accept new operands, next state=START, out_valid<=0 on the same edge.
- Upstream or downstream signals changing in START/WAIT have no effect (in_ready=0).
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. An in-flight result is discarded. A complete arriving after reset while in IDLE is ignored.
- Latency: accept edge → op_start high the next cycle. out_valid rises on the edge after op_complete is first sampled high with cnt>=1.

Test Plan:
- Single op: a=0x3F800000 (1.0), b=0x40000000 (2.0), rnd=0; stub completes 4 cycles after op_start with z=0x3F000000, status=0 → exactly one op_start pulse; out_z=0x3F000000, out_err=0, out_valid one cycle after complete.
- Back-to-back: out_ready=1 with 3 queued pairs (6/3, 9/3, 1/4) → results 0x40000000, 0x40400000, 0x3E800000 in order. Each HOLD→START transition shows no IDLE cycle.
- Backpressure: out_ready=0 for 10 cycles during HOLD → out_z/out_status stable, in_ready=0, no op_start; result accepted when out_ready rises.
- Stale complete: stub holds op_complete=1 continuously from the prior op → complete is ignored in the first WAIT cycle; capture happens at cnt=1.
- Timeout: stub never completes, TIMEOUT_CYC=16 → out_valid after 16 WAIT cycles with out_err=1, out_z=0, out_status=0.
- Reset mid-WAIT: assert rst at cnt=2 → next cycle IDLE with busy=0 and out_valid=0. A subsequent stub complete produces no output.
